spike_network: RTL and testbench
================================

# spike_network

Spike arbitration and broadcast stage sitting between the `neuron` array and itself. It collects every neuron's 2-bit spike output and selects one firing neuron per network round by round-robin serial scan. It broadcasts that neuron's `{spike, id}` word back to all neurons and pulses `networkDone` to release them from their NETWORK wait. It also reports per-round firing statistics to the top.

## Interface
- `NUM_NEURON`, 512, number of neuron instances (spike vector entries)
- `NEURON_ID_WIDTH`, 9, neuron index width
- `TEN_DATA_WIDTH`, 2, spike code width (0 none, 1 positive, 2 negative, 3 invalid)
- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `en`  in  1  global enable; low freezes all state
- `active_neuron`  in  NEURON_ID_WIDTH  number of scanned neurons N (indices 0..N-1)
- `req`  in  1  round request (AND of all neurons' `en_network`)
- `spike_vec`  in  NUM_NEURON*TEN_DATA_WIDTH  neuron i's spike in bits [2i+1:2i]
- `spike_bcast`  out  TEN_DATA_WIDTH+NEURON_ID_WIDTH  registered `{code, id}` to every neuron's `spike_in`
- `networkDone`  out  1  one-cycle round-complete pulse
- `busy`  out  1  high in SCAN/DONE/WAIT_LOW
- `fired_cnt`  out  NEURON_ID_WIDTH+1  number of valid spikes (code 1 or 2) found in last round
- `round_cnt`  out  16  completed rounds, wraps at 65535→0

## Operation
- Reset values: state IDLE, `spike_bcast`=0, `networkDone`=0, `busy`=0, `fired_cnt`=0, `round_cnt`=0, round-robin pointer `ptr`=0.
- IDLE: on `req`=1, latch `n`=`active_neuron`, set `idx`=(`ptr`<`n` ? `ptr` : 0), scanned=0, found=0, count=0, then go to SCAN. If `n`=0, go directly to DONE with a null result.
- SCAN: examine one entry per cycle, `spike_vec[idx]`.
  - If the code is 1 or 2, increment count.
  - If found=0 when that valid code is seen, latch winner id=`idx` and winner code, and set found=1.
  - Code 3 is treated as no spike.
  - `idx` increments and wraps n-1→0.
  - After n examined entries, go to DONE.
- DONE (one cycle): `networkDone`=1.
  - `spike_bcast` already holds `{winner code, winner id}` if found, else {0,0}; it was registered on the SCAN→DONE edge.
  - `fired_cnt` is updated on the same edge as `spike_bcast`.
  - If found, `ptr` = winner id+1, wrapping n→0; otherwise `ptr` is unchanged.
  - `round_cnt`+1.
  - Next state is WAIT_LOW.
- WAIT_LOW: stay until `req`=0, then go to IDLE. This prevents double rounds when `req` is still high.
- `spike_bcast` holds its value until the next SCAN→DONE edge, because neurons sample it in the cycle after `networkDone`.
- `spike_vec` must be stable during SCAN. Neurons hold their outputs while in NETWORK; the block does not re-check this.

## Timing
- `req` sampled high at edge E0 → SCAN for n cycles → `networkDone` high in cycle n+1 after E0, for exactly one cycle.
- n=0: `networkDone` high in the cycle after E0.
- `networkDone` = (state==DONE) & `en`; it is combinational from the registered state only, not from `req`.
- `en`=0: no state, counter or output register changes. `networkDone` is forced 0; DONE resumes and pulses when `en` returns.
- Asynchronous `reset` mid-scan: immediately restores all reset values. No `networkDone` is produced for the aborted round.
- `active_neuron` changes during a round are ignored until the next IDLE→SCAN.
- `req` deasserting during SCAN does not abort the round.

## Test plan
- Reset: assert `reset` mid-SCAN → all outputs 0 at once; after release with `req`=0, stays IDLE and `networkDone` never pulses.
- N=8, `ptr`=0, neuron 3 code 1, neuron 5 code 2, `req` high at E0 → `networkDone` only in cycle 9 after E0; `spike_bcast`={2'b01,9'd3}; `fired_cnt`=2; `ptr`=4; `round_cnt`=1.
- Round-robin:
  - Same vector again, `req` toggled low then high → `spike_bcast`={2'b10,9'd5}, `ptr`=6.
  - Third round wraps past index 7 → winner 3 again.
- No valid spikes (all codes 0 plus neuron 2 code 3), N=8 → `spike_bcast`=0, `fired_cnt`=0, `ptr` unchanged, `networkDone` still pulses at cycle 9.
- N=0 with `req` high → `networkDone` one cycle after acceptance, `spike_bcast`=0. Then hold `req` high through WAIT_LOW → no second pulse until `req` drops and rises.
- `en` low for 3 cycles mid-SCAN (N=8, winner 6) → `networkDone` delayed by exactly 3 cycles; `spike_bcast`={code6,9'd6} unchanged by the pause.

Source files
------------

// File: rtl/spike_network.sv
// rtl/spike_network.sv - round-robin spike arbiter: serial scan of the neuron spike vector,
// one winner broadcast per round with a networkDone pulse and firing statistics.
module spike_network #(
    parameter int NUM_NEURON      = 512,
    parameter int NEURON_ID_WIDTH = 9,
    parameter int TEN_DATA_WIDTH  = 2
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      en,
    input  logic [NEURON_ID_WIDTH-1:0]                active_neuron,
    input  logic                                      req,
    input  logic [NUM_NEURON*TEN_DATA_WIDTH-1:0]      spike_vec,
    output logic [TEN_DATA_WIDTH+NEURON_ID_WIDTH-1:0] spike_bcast,
    output logic                                      networkDone,
    output logic                                      busy,
    output logic [NEURON_ID_WIDTH:0]                  fired_cnt,
    output logic [15:0]                               round_cnt
);
    localparam int SEL_W = $clog2(NUM_NEURON * TEN_DATA_WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE, S_WAIT_LOW} state_t;

    state_t                                     state_q, state_d;
    logic [NEURON_ID_WIDTH-1:0]                 n_q, n_d;
    logic [NEURON_ID_WIDTH-1:0]                 idx_q, idx_d;
    logic [NEURON_ID_WIDTH-1:0]                 ptr_q, ptr_d;
    logic [NEURON_ID_WIDTH:0]                   scanned_q, scanned_d;
    logic [NEURON_ID_WIDTH:0]                   count_q, count_d;
    logic                                       found_q, found_d;
    logic [NEURON_ID_WIDTH-1:0]                 win_id_q, win_id_d;
    logic [TEN_DATA_WIDTH-1:0]                  win_code_q, win_code_d;
    logic [TEN_DATA_WIDTH+NEURON_ID_WIDTH-1:0]  bcast_q, bcast_d;
    logic [NEURON_ID_WIDTH:0]                   fired_q, fired_d;
    logic [15:0]                                round_q, round_d;

    logic [SEL_W-1:0]          sel;
    logic [TEN_DATA_WIDTH-1:0] code;
    logic                      code_valid;

    assign sel        = SEL_W'(idx_q) * SEL_W'(TEN_DATA_WIDTH);
    assign code       = spike_vec[sel +: TEN_DATA_WIDTH];
    // Code 3 is an invalid encoding and counts as no spike.
    assign code_valid = (code == TEN_DATA_WIDTH'(1)) || (code == TEN_DATA_WIDTH'(2));

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        idx_d      = idx_q;
        ptr_d      = ptr_q;
        scanned_d  = scanned_q;
        count_d    = count_q;
        found_d    = found_q;
        win_id_d   = win_id_q;
        win_code_d = win_code_q;
        bcast_d    = bcast_q;
        fired_d    = fired_q;
        round_d    = round_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    n_d        = active_neuron;
                    idx_d      = (ptr_q < active_neuron) ? ptr_q : '0;
                    scanned_d  = '0;
                    count_d    = '0;
                    found_d    = 1'b0;
                    win_id_d   = '0;
                    win_code_d = '0;
                    if (active_neuron == '0) begin
                        state_d = S_DONE;
                        bcast_d = '0;
                        fired_d = '0;
                    end else begin
                        state_d = S_SCAN;
                    end
                end
            end
            S_SCAN: begin
                if (code_valid) begin
                    count_d = count_q + 1'b1;
                    if (!found_q) begin
                        found_d    = 1'b1;
                        win_id_d   = idx_q;
                        win_code_d = code;
                    end
                end
                idx_d     = (idx_q == n_q - 1'b1) ? '0 : idx_q + 1'b1;
                scanned_d = scanned_q + 1'b1;
                // Results are registered on the last scan edge so they are stable throughout DONE.
                if (scanned_q + 1'b1 == {1'b0, n_q}) begin
                    state_d = S_DONE;
                    bcast_d = found_d ? {win_code_d, win_id_d} : '0;
                    fired_d = count_d;
                end
            end
            S_DONE: begin
                if (found_q) begin
                    ptr_d = ({1'b0, win_id_q} + 1'b1 == {1'b0, n_q}) ? '0 : win_id_q + 1'b1;
                end
                round_d = round_q + 16'd1;
                state_d = S_WAIT_LOW;
            end
            S_WAIT_LOW: begin
                if (!req) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            n_q        <= '0;
            idx_q      <= '0;
            ptr_q      <= '0;
            scanned_q  <= '0;
            count_q    <= '0;
            found_q    <= 1'b0;
            win_id_q   <= '0;
            win_code_q <= '0;
            bcast_q    <= '0;
            fired_q    <= '0;
            round_q    <= '0;
        end else if (en) begin
            state_q    <= state_d;
            n_q        <= n_d;
            idx_q      <= idx_d;
            ptr_q      <= ptr_d;
            scanned_q  <= scanned_d;
            count_q    <= count_d;
            found_q    <= found_d;
            win_id_q   <= win_id_d;
            win_code_q <= win_code_d;
            bcast_q    <= bcast_d;
            fired_q    <= fired_d;
            round_q    <= round_d;
        end
    end

    assign spike_bcast = bcast_q;
    assign fired_cnt   = fired_q;
    assign round_cnt   = round_q;
    assign networkDone = (state_q == S_DONE) && en;
    assign busy        = (state_q != S_IDLE);
endmodule

// File: tb/tb_spike_network.sv
// tb/tb_spike_network.sv - self-checking bench for spike_network against a round-level
// arbitration model.
module tb_spike_network;
    localparam int NN = 512;
    localparam int IW = 9;
    localparam int DW = 2;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 en;
    logic [IW-1:0]        active_neuron;
    logic                 req;
    logic [NN*DW-1:0]     spike_vec;
    logic [DW+IW-1:0]     spike_bcast;
    logic                 networkDone;
    logic                 busy;
    logic [IW:0]          fired_cnt;
    logic [15:0]          round_cnt;

    int vectors = 0;
    int errors  = 0;
    logic [1:0] codes [NN];
    int ptr_m    = 0;
    int rounds_m = 0;

    spike_network dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .active_neuron(active_neuron),
        .req          (req),
        .spike_vec    (spike_vec),
        .spike_bcast  (spike_bcast),
        .networkDone  (networkDone),
        .busy         (busy),
        .fired_cnt    (fired_cnt),
        .round_cnt    (round_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_codes();
        for (int i = 0; i < NN; i++) codes[i] = 2'd0;
    endtask

    task automatic apply_codes();
        for (int i = 0; i < NN; i++) spike_vec[i*DW +: DW] = codes[i];
    endtask

    // Model: scan n entries starting at the pointer, first valid code wins, count all valid codes.
    task automatic run_round(input string tag, input int n, input int pause_at);
        int start, idx, cnt, win, wcode, exp_cycle, first, pulses;
        logic [31:0] exp_bcast;
        start = (ptr_m < n) ? ptr_m : 0;
        cnt   = 0;
        win   = -1;
        wcode = 0;
        for (int k = 0; k < n; k++) begin
            idx = (start + k) % n;
            if (codes[idx] == 2'd1 || codes[idx] == 2'd2) begin
                cnt++;
                if (win < 0) begin
                    win   = idx;
                    wcode = int'(codes[idx]);
                end
            end
        end
        exp_bcast = (win < 0) ? 32'd0 : 32'((wcode << IW) | win);
        if (win >= 0) ptr_m = (win + 1 == n) ? 0 : win + 1;
        rounds_m  = (rounds_m + 1) & 16'hffff;
        exp_cycle = n + 1 + ((pause_at > 0) ? 3 : 0);

        active_neuron = IW'(n);
        apply_codes();
        req    = 1'b1;
        first  = -1;
        pulses = 0;
        // req stays high through WAIT_LOW so a second round would show up as an extra pulse.
        for (int c = 1; c <= exp_cycle + 4; c++) begin
            @(posedge clk); #1;
            if (networkDone) begin
                pulses++;
                if (first < 0) first = c;
            end
            if (pause_at > 0 && c == pause_at) en = 1'b0;
            if (pause_at > 0 && c == pause_at + 3) en = 1'b1;
        end
        req = 1'b0;
        @(posedge clk); #1;
        check({tag, "_pulses"}, 32'(pulses), 32'd1);
        check({tag, "_done_cycle"}, 32'(first), 32'(exp_cycle));
        check({tag, "_bcast"}, 32'(spike_bcast), exp_bcast);
        check({tag, "_fired"}, 32'(fired_cnt), 32'(cnt));
        check({tag, "_rounds"}, 32'(round_cnt), 32'(rounds_m));
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int n, pa, pulses, busy_seen;
        reset = 1'b0;
        en = 1'b1;
        req = 1'b0;
        active_neuron = '0;
        spike_vec = '0;
        clear_codes();
        #2 reset = 1'b1;
        #1;
        check("rst_bcast", 32'(spike_bcast), 32'd0);
        check("rst_done", 32'(networkDone), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_fired", 32'(fired_cnt), 32'd0);
        check("rst_rounds", 32'(round_cnt), 32'd0);
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        @(posedge clk); #1;

        clear_codes();
        codes[3] = 2'd1;
        codes[5] = 2'd2;
        run_round("rr1", 8, 0);
        check("rr1_const_bcast", 32'(spike_bcast), 32'h203);
        run_round("rr2", 8, 0);
        check("rr2_const_bcast", 32'(spike_bcast), 32'h405);
        run_round("rr3", 8, 0);
        check("rr3_const_bcast", 32'(spike_bcast), 32'h203);

        clear_codes();
        codes[2] = 2'd3;
        run_round("none", 8, 0);
        run_round("n0", 0, 0);

        clear_codes();
        codes[6] = 2'd2;
        run_round("pause", 8, 4);
        check("pause_const_bcast", 32'(spike_bcast), 32'h406);

        for (int r = 0; r < 30; r++) begin
            n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 511)) : int'($urandom_range(0, 16));
            for (int i = 0; i < NN; i++)
                codes[i] = ($urandom_range(0, 9) < 7) ? 2'd0 : 2'($urandom_range(1, 3));
            pa = (n >= 2 && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, n)) : 0;
            run_round($sformatf("rand%0d", r), n, pa);
        end

        clear_codes();
        codes[1] = 2'd1;
        active_neuron = IW'(8);
        apply_codes();
        req = 1'b1;
        repeat (4) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_bcast", 32'(spike_bcast), 32'd0);
        check("mid_rst_done", 32'(networkDone), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_fired", 32'(fired_cnt), 32'd0);
        check("mid_rst_rounds", 32'(round_cnt), 32'd0);
        ptr_m    = 0;
        rounds_m = 0;
        req      = 1'b0;
        @(posedge clk);
        #3 reset = 1'b0;
        pulses    = 0;
        busy_seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (networkDone) pulses++;
            if (busy) busy_seen++;
        end
        check("post_rst_pulses", 32'(pulses), 32'd0);
        check("post_rst_busy", 32'(busy_seen), 32'd0);

        clear_codes();
        codes[0] = 2'd2;
        codes[7] = 2'd1;
        run_round("post_rst", 8, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
